// File: rtl/cache_arbiter_if.sv
// L1/L2 miss-path bundle between the split I/D caches, the arbiter and the unified L2.
interface cache_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
);
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;
  logic                  l2_read;
  logic                  l2_write;
  logic [ADDR_WIDTH-1:0] l2_addr;
  logic [LINE_WIDTH-1:0] l2_wdata;
  logic [LINE_WIDTH-1:0] l2_rdata;
  logic                  l2_resp;

  // master: the caches plus L2 surrounding the arbiter
  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_addr, l2_wdata
  );

  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, l2_rdata, l2_resp,
    output i_rdata, i_resp, d_rdata, d_resp, l2_read, l2_write, l2_addr, l2_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter granting I-cache and D-cache line misses to the unified L2, one at a time.
module cache_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  cache_arbiter_if.slave   bus
);
  localparam int OFFS = $clog2(LINE_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t                state, state_nxt;
  logic                  last_grant;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  is_write_q;
  logic                  i_req, d_req, grant_i, grant_d;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  // Returned line is broadcast; only the resp pulse says who owns it.
  assign bus.i_rdata  = bus.l2_rdata;
  assign bus.d_rdata  = bus.l2_rdata;
  assign bus.l2_addr  = addr_q;
  assign bus.l2_wdata = wdata_q;

  always_comb begin
    state_nxt    = state;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    bus.l2_read  = 1'b0;
    bus.l2_write = 1'b0;
    bus.i_resp   = 1'b0;
    bus.d_resp   = 1'b0;
    case (state)
      IDLE: begin
        // on a tie the side that did not win last time goes first
        grant_i = i_req & (~d_req | last_grant);
        grant_d = d_req & (~i_req | ~last_grant);
        if (grant_i)      state_nxt = SERVE_I;
        else if (grant_d) state_nxt = SERVE_D;
      end
      SERVE_I: begin
        bus.l2_read = 1'b1;
        if (bus.l2_resp) begin
          bus.i_resp = 1'b1;
          state_nxt  = IDLE;
        end
      end
      SERVE_D: begin
        bus.l2_read  = ~is_write_q;
        bus.l2_write = is_write_q;
        if (bus.l2_resp) begin
          bus.d_resp = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_i) begin
        addr_q     <= {bus.i_addr[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
        is_write_q <= 1'b0;
        last_grant <= 1'b0;
      end else if (grant_d) begin
        addr_q     <= {bus.d_addr[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
        wdata_q    <= bus.d_wdata;
        is_write_q <= bus.d_write;
        last_grant <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: inputs change just after the falling edge, outputs checked 1ns later.
module tb_cache_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  localparam logic [127:0] LINE_A5 = {16{8'hA5}};
  localparam logic [127:0] LINE_WB = 128'h0123456789abcdef_fedcba9876543210;
  localparam logic [127:0] LINE_5A = {16{8'h5A}};

  cache_arbiter_if #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) bus ();
  cache_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.i_read = 0; bus.i_addr = '0;
    bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.l2_resp = 0;
  endtask

  initial begin
    idle_inputs();
    bus.l2_rdata = LINE_5A;
    #12;
    // reset state
    chk("rst l2_read", bus.l2_read, 0);
    chk("rst l2_write", bus.l2_write, 0);
    chk("rst l2_addr", bus.l2_addr, 0);
    chk("rst l2_wdata", bus.l2_wdata, 0);
    chk("rst i_resp", bus.i_resp, 0);
    chk("rst d_resp", bus.d_resp, 0);
    chk("rst i_rdata", bus.i_rdata, LINE_5A);
    chk("rst d_rdata", bus.d_rdata, LINE_5A);
    cyc(); rst_n = 1'b1;

    // I miss alone, L2 answers on the third serve cycle
    cyc(); bus.i_read = 1; bus.i_addr = 16'h1237; #1;
    chk("i0 idle l2_read", bus.l2_read, 0);
    cyc(); #1;
    chk("i0 l2_read", bus.l2_read, 1);
    chk("i0 l2_write", bus.l2_write, 0);
    chk("i0 l2_addr", bus.l2_addr, 16'h1230);
    chk("i0 wait i_resp", bus.i_resp, 0);
    cyc(); #1; chk("i0 wait2 i_resp", bus.i_resp, 0);
    cyc(); bus.l2_resp = 1; bus.l2_rdata = LINE_A5; #1;
    chk("i0 i_resp", bus.i_resp, 1);
    chk("i0 i_rdata", bus.i_rdata, LINE_A5);
    chk("i0 d_resp", bus.d_resp, 0);
    chk("i0 hold l2_read", bus.l2_read, 1);
    cyc(); bus.i_read = 0; bus.l2_resp = 0; #1;
    chk("i0 i_resp drop", bus.i_resp, 0);
    chk("i0 idle after", bus.l2_read, 0);

    // D write-back
    cyc(); bus.d_write = 1; bus.d_addr = 16'h4008; bus.d_wdata = LINE_WB; #1;
    cyc(); #1;
    chk("dw l2_write", bus.l2_write, 1);
    chk("dw l2_read", bus.l2_read, 0);
    chk("dw l2_addr", bus.l2_addr, 16'h4000);
    chk("dw l2_wdata", bus.l2_wdata, LINE_WB);
    cyc(); bus.l2_resp = 1; #1;
    chk("dw d_resp", bus.d_resp, 1);
    chk("dw i_resp", bus.i_resp, 0);
    cyc(); bus.d_write = 0; bus.l2_resp = 0; #1;
    chk("dw d_resp drop", bus.d_resp, 0);
    chk("dw idle l2_write", bus.l2_write, 0);

    // simultaneous requests straight after a reset: I first, then D
    cyc(); rst_n = 0; #1; cyc(); rst_n = 1;
    cyc(); bus.i_read = 1; bus.i_addr = 16'h2345;
    bus.d_read = 1; bus.d_addr = 16'h6789; #1;
    cyc(); #1;
    chk("sim I l2_addr", bus.l2_addr, 16'h2340);
    chk("sim I l2_read", bus.l2_read, 1);
    bus.l2_resp = 1; #1;
    chk("sim i_resp", bus.i_resp, 1);
    chk("sim d_resp early", bus.d_resp, 0);
    cyc(); bus.i_read = 0; bus.l2_resp = 0; #1;
    chk("sim idle gap", bus.l2_read, 0);
    cyc(); #1;
    chk("sim D l2_addr", bus.l2_addr, 16'h6780);
    chk("sim D l2_read", bus.l2_read, 1);
    chk("sim D l2_write", bus.l2_write, 0);
    bus.l2_resp = 1; #1;
    chk("sim d_resp", bus.d_resp, 1);
    chk("sim i_resp late", bus.i_resp, 0);
    cyc(); bus.d_read = 0; bus.l2_resp = 0;

    // round-robin: both request together each round; last winner was D
    for (int t = 0; t < 4; t++) begin
      bit exp_d;
      exp_d = (t % 2) == 1;
      cyc(); bus.i_read = 1; bus.i_addr = 16'h100F; bus.d_read = 1; bus.d_addr = 16'h200F; #1;
      cyc(); #1;
      chk($sformatf("rr%0d l2_addr", t), bus.l2_addr, exp_d ? 16'h2000 : 16'h1000);
      bus.l2_resp = 1; #1;
      chk($sformatf("rr%0d i_resp", t), bus.i_resp, !exp_d);
      chk($sformatf("rr%0d d_resp", t), bus.d_resp, exp_d);
      cyc(); bus.i_read = 0; bus.d_read = 0; bus.l2_resp = 0;
    end

    // reset while D (read+write => write) waits on L2
    cyc(); bus.d_read = 1; bus.d_write = 1; bus.d_addr = 16'h3004; bus.d_wdata = LINE_WB; #1;
    cyc(); #1;
    chk("mr l2_write", bus.l2_write, 1);
    chk("mr l2_read", bus.l2_read, 0);
    chk("mr l2_addr", bus.l2_addr, 16'h3000);
    rst_n = 0; #1;
    chk("mr async l2_write", bus.l2_write, 0);
    chk("mr async l2_read", bus.l2_read, 0);
    chk("mr async d_resp", bus.d_resp, 0);
    bus.l2_resp = 1; #1;
    chk("mr resp in rst", bus.d_resp, 0);
    cyc(); bus.l2_resp = 0; rst_n = 1; #1;
    chk("mr idle l2_write", bus.l2_write, 0);
    cyc(); #1;
    chk("mr regrant l2_write", bus.l2_write, 1);
    chk("mr regrant l2_addr", bus.l2_addr, 16'h3000);
    bus.l2_resp = 1; #1;
    chk("mr d_resp", bus.d_resp, 1);
    cyc(); bus.d_read = 0; bus.d_write = 0; bus.l2_resp = 0;

    // spurious l2_resp in IDLE
    cyc(); bus.l2_resp = 1; #1;
    chk("sp i_resp", bus.i_resp, 0);
    chk("sp d_resp", bus.d_resp, 0);
    cyc(); bus.l2_resp = 0; #1;
    chk("sp l2_read", bus.l2_read, 0);
    chk("sp l2_write", bus.l2_write, 0);
    bus.i_read = 1; bus.i_addr = 16'h7FFF;
    cyc(); #1;
    chk("sp then grant", bus.l2_read, 1);
    chk("sp then addr", bus.l2_addr, 16'h7FF0);
    bus.l2_resp = 1; #1;
    chk("sp then i_resp", bus.i_resp, 1);
    cyc(); idle_inputs();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  // hard stop so a broken handshake can never hang the run
  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
